// File: rtl/alu_arb_ctrl.sv
// Two-requester round-robin front end for a 4-bit ALU (ADD/SUB/MUL/DIV).
// One command in flight: IDLE accepts, EXEC computes, RESP holds result until taken.
module alu_arb_ctrl #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [1:0]       r0_op,
  input  logic [3:0]       r0_a,
  input  logic [3:0]       r0_b,
  input  logic             r0_cin,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [1:0]       r1_op,
  input  logic [3:0]       r1_a,
  input  logic [3:0]       r1_b,
  input  logic             r1_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [7:0]       rsp_data,
  output logic             rsp_flag,
  output logic             rsp_err,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_e;

  state_e           state_q, state_d;
  logic             last_grant_q;
  op_e              op_q;
  logic [3:0]       a_q, b_q;
  logic             cin_q, id_q;
  logic             rsp_id_q, rsp_flag_q, rsp_err_q;
  logic [7:0]       rsp_data_q;
  logic [CNT_W-1:0] ops_done_q;

  logic       gnt, any_v, hs_cmd, hs_rsp;
  logic [7:0] res_data;
  logic       res_flag, res_err;

  // On a tie, the requester not granted last time wins.
  always_comb begin
    gnt = 1'b0;
    if (r0_valid && r1_valid) gnt = ~last_grant_q;
    else if (r1_valid)        gnt = 1'b1;
  end

  assign any_v    = r0_valid | r1_valid;
  assign r0_ready = rst_n && (state_q == IDLE) && any_v && !gnt;
  assign r1_ready = rst_n && (state_q == IDLE) && any_v && gnt;
  assign hs_cmd   = (r0_valid && r0_ready) || (r1_valid && r1_ready);
  assign hs_rsp   = (state_q == RESP) && rsp_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hs_cmd) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (hs_rsp) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    res_data = '0;
    res_flag = 1'b0;
    res_err  = 1'b0;
    case (op_q)
      OP_ADD: {res_flag, res_data[3:0]} = {1'b0, a_q} + {1'b0, b_q} + {4'b0, cin_q};
      OP_SUB: {res_flag, res_data[3:0]} = {1'b0, a_q} - {1'b0, b_q} - {4'b0, cin_q};
      OP_MUL: res_data = {4'b0, a_q} * {4'b0, b_q};
      OP_DIV: begin
        if (b_q == 4'd0) res_err  = 1'b1;
        else             res_data = {a_q % b_q, a_q / b_q};
      end
      default: res_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      op_q         <= OP_ADD;
      a_q          <= '0;
      b_q          <= '0;
      cin_q        <= 1'b0;
      id_q         <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= '0;
      rsp_flag_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
      ops_done_q   <= '0;
    end else begin
      state_q <= state_d;
      if (hs_cmd) begin
        last_grant_q <= gnt;
        id_q         <= gnt;
        op_q         <= op_e'(gnt ? r1_op : r0_op);
        a_q          <= gnt ? r1_a   : r0_a;
        b_q          <= gnt ? r1_b   : r0_b;
        cin_q        <= gnt ? r1_cin : r0_cin;
      end
      if (state_q == EXEC) begin
        rsp_id_q   <= id_q;
        rsp_data_q <= res_data;
        rsp_flag_q <= res_flag;
        rsp_err_q  <= res_err;
      end
      if (hs_rsp) ops_done_q <= ops_done_q + CNT_W'(1);
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_flag  = rsp_flag_q;
  assign rsp_err   = rsp_err_q;
  assign ops_done  = ops_done_q;

endmodule

// File: tb/tb_alu_arb_ctrl.sv
// Directed self-checking bench for alu_arb_ctrl: ALU results, latency, arbitration,
// response back-pressure, reset mid-response and counter wrap.
module tb_alu_arb_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       r0_valid, r0_ready, r0_cin, r1_valid, r1_ready, r1_cin;
  logic [1:0] r0_op, r1_op;
  logic [3:0] r0_a, r0_b, r1_a, r1_b;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_flag, rsp_err, busy;
  logic [7:0] rsp_data, ops_done;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [7:0]  exp_ops = '0;

  always #5 clk = ~clk;

  alu_arb_ctrl #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op), .r0_a(r0_a), .r0_b(r0_b), .r0_cin(r0_cin),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op), .r1_a(r1_a), .r1_b(r1_b), .r1_cin(r1_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_flag(rsp_flag), .rsp_err(rsp_err), .busy(busy), .ops_done(ops_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic id, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic cin);
    if (id) begin r1_op = op; r1_a = a; r1_b = b; r1_cin = cin; r1_valid = 1'b1; end
    else    begin r0_op = op; r0_a = a; r0_b = b; r0_cin = cin; r0_valid = 1'b1; end
  endtask

  // Full directed op: grant, N+1 no response, N+2 response contents, then handshake.
  task automatic do_op(input logic id, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic cin, input logic [7:0] ed, input logic ef, input logic ee);
    set_cmd(id, op, a, b, cin);
    #1;
    chk("rdy_own",   id ? r1_ready : r0_ready, 1);
    chk("rdy_other", id ? r0_ready : r1_ready, 0);
    tick();
    r0_valid = 1'b0; r1_valid = 1'b0;
    chk("lat_n1", rsp_valid, 0);
    chk("busy_exec", busy, 1);
    tick();
    chk("lat_n2", rsp_valid, 1);
    chk("rsp_id", rsp_id, id);
    chk("rsp_data", rsp_data, ed);
    chk("rsp_flag", rsp_flag, ef);
    chk("rsp_err", rsp_err, ee);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    exp_ops++;
    chk("ops_done", ops_done, exp_ops);
    chk("busy_idle", busy, 0);
  endtask

  task automatic quick_op();
    set_cmd(1'b0, 2'd0, 4'd1, 4'd1, 1'b0);
    tick();
    r0_valid = 1'b0;
    tick();
    tick();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    exp_ops++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    exp_ops = '0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic found;
    rst_n = 1'b0; rsp_ready = 1'b0;
    r0_valid = 1'b1; r1_valid = 1'b1;
    r0_op = '0; r0_a = '0; r0_b = '0; r0_cin = 1'b0;
    r1_op = '0; r1_a = '0; r1_b = '0; r1_cin = 1'b0;
    #12;
    chk("rst_r0_rdy", r0_ready, 0);
    chk("rst_r1_rdy", r1_ready, 0);
    chk("rst_vld", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_ops", ops_done, 0);
    r0_valid = 1'b0; r1_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    do_op(1'b0, 2'd0, 4'd9,  4'd8,  1'b1, 8'h02, 1'b1, 1'b0);
    do_op(1'b1, 2'd1, 4'd3,  4'd5,  1'b0, 8'h0E, 1'b1, 1'b0);
    do_op(1'b0, 2'd2, 4'd15, 4'd15, 1'b0, 8'hE1, 1'b0, 1'b0);
    do_op(1'b1, 2'd3, 4'd13, 4'd4,  1'b0, 8'h13, 1'b0, 1'b0);
    do_op(1'b0, 2'd3, 4'd7,  4'd0,  1'b0, 8'h00, 1'b0, 1'b1);
    do_op(1'b1, 2'd0, 4'd3,  4'd4,  1'b0, 8'h07, 1'b0, 1'b0);
    do_op(1'b0, 2'd1, 4'd7,  4'd2,  1'b1, 8'h04, 1'b0, 1'b0);
    do_op(1'b1, 2'd2, 4'd3,  4'd5,  1'b1, 8'h0F, 1'b0, 1'b0);
    do_op(1'b0, 2'd1, 4'd0,  4'd15, 1'b1, 8'h00, 1'b1, 1'b0);

    // Back-pressure: 5 stalled cycles, r1 asserts then drops valid meanwhile.
    set_cmd(1'b0, 2'd0, 4'd5, 4'd6, 1'b0);
    tick();
    r0_valid = 1'b0;
    tick();
    set_cmd(1'b1, 2'd0, 4'd1, 4'd1, 1'b0);
    for (int c = 0; c < 5; c++) begin
      chk("stall_vld", rsp_valid, 1);
      chk("stall_data", rsp_data, 8'h0B);
      chk("stall_id", rsp_id, 0);
      chk("stall_r1_rdy", r1_ready, 0);
      chk("stall_ops", ops_done, exp_ops);
      tick();
    end
    r1_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    exp_ops++;
    chk("stall_ops_done", ops_done, exp_ops);

    // last_grant is r0, so a tie goes to r1; then reset while that response is pending.
    set_cmd(1'b0, 2'd0, 4'd1, 4'd2, 1'b0);
    set_cmd(1'b1, 2'd0, 4'd2, 4'd2, 1'b0);
    #1;
    chk("tie_r1_rdy", r1_ready, 1);
    chk("tie_r0_rdy", r0_ready, 0);
    tick();
    r0_valid = 1'b0; r1_valid = 1'b0;
    tick();
    chk("pre_rst_vld", rsp_valid, 1);
    rst_n = 1'b0;
    #1;
    exp_ops = '0;
    chk("mrst_vld", rsp_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_data", rsp_data, 0);
    chk("mrst_id", rsp_id, 0);
    chk("mrst_flag", rsp_flag, 0);
    chk("mrst_ops", ops_done, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_vld", rsp_valid, 0);

    // Round-robin with both requesters continuously valid.
    set_cmd(1'b0, 2'd0, 4'd1, 4'd1, 1'b0);
    set_cmd(1'b1, 2'd0, 4'd2, 4'd2, 1'b0);
    rsp_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      found = 1'b0;
      for (int c = 0; c < 10 && !found; c++) begin
        chk("rr_both_rdy", r0_ready & r1_ready, 0);
        if (r0_ready || r1_ready) begin
          found = 1'b1;
          chk("rr_gnt", r1_ready, k % 2);
        end else begin
          tick();
        end
      end
      chk("rr_found", found, 1);
      tick();
      if (k == 3) begin r0_valid = 1'b0; r1_valid = 1'b0; end
    end
    for (int c = 0; c < 10 && busy; c++) tick();
    chk("rr_drain", busy, 0);
    rsp_ready = 1'b0;
    exp_ops = exp_ops + 8'd4;
    chk("rr_ops", ops_done, exp_ops);

    // Counter wrap 255 -> 0.
    do_reset();
    tick();
    for (int i = 0; i < 255; i++) quick_op();
    chk("wrap_255", ops_done, 8'd255);
    quick_op();
    chk("wrap_0", ops_done, exp_ops);
    chk("wrap_0_lit", ops_done, 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
